// File: rtl/pio_pkg.sv
// Shared definitions for the parallel I/O port: register offsets, edge-mode
// encodings and the per-bit edge detector used by the input path.
package pio_pkg;

    // Register word offsets on the slave bus
    localparam logic [2:0] PIO_DATA    = 3'd0;
    localparam logic [2:0] PIO_DIR     = 3'd1;
    localparam logic [2:0] PIO_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_EDGECAP = 3'd3;
    localparam logic [2:0] PIO_OUTSET  = 3'd4;
    localparam logic [2:0] PIO_OUTCLR  = 3'd5;

    // Edge capture modes
    localparam int unsigned PIO_EDGE_RISE = 0;
    localparam int unsigned PIO_EDGE_FALL = 1;
    localparam int unsigned PIO_EDGE_ANY  = 2;

    localparam int unsigned PIO_MAX_WIDTH = 32;

    // Per-bit edge detect between the current synchronised sample and its history
    function automatic logic [PIO_MAX_WIDTH-1:0] pio_edge_detect(
        input int unsigned              mode,
        input logic [PIO_MAX_WIDTH-1:0] cur,
        input logic [PIO_MAX_WIDTH-1:0] prev
    );
        case (mode)
            PIO_EDGE_FALL: return ~cur & prev;
            PIO_EDGE_ANY:  return cur ^ prev;
            default:       return cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_ext_if.sv
// Zero-wait-state slave bus bundle for the parallel I/O port.
interface pio_ext_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus one history stage; emits the synchronised
// input and a one-cycle edge pulse per bit for the selected edge mode.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = PIO_EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d, sync_q;
    logic [WIDTH-1:0]                  prev_d, prev_q;

    // Shift the pins through the synchroniser, then into the history register
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge pulse is high for the one cycle in which in_sync differs from history
    always_comb begin
        in_sync    = sync_q[SYNC_STAGES-1];
        edge_pulse = WIDTH'(pio_edge_detect(EDGE_MODE, PIO_MAX_WIDTH'(in_sync),
                                            PIO_MAX_WIDTH'(prev_q)));
    end

endmodule

// File: rtl/pio_ext.sv
// Parametrised parallel I/O port: output data with atomic set/clear, per-bit
// direction, synchronised input reads, sticky edge capture and maskable irq.
module pio_ext
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int unsigned      EDGE_MODE   = PIO_EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_ext_if.slave         bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] out_d, out_q;
    logic [WIDTH-1:0] dir_d, dir_q;
    logic [WIDTH-1:0] mask_d, mask_q;
    logic [WIDTH-1:0] cap_d, cap_q;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic             wr_en;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Register write decode; a new edge overrides a same-cycle write-1-clear
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en) begin
            case (bus.address)
                PIO_DATA:    out_d   = bus.writedata;
                PIO_DIR:     dir_d   = bus.writedata;
                PIO_IRQMASK: mask_d  = bus.writedata;
                PIO_EDGECAP: cap_clr = bus.writedata;
                PIO_OUTSET:  out_d   = out_q | bus.writedata;
                PIO_OUTCLR:  out_d   = out_q & ~bus.writedata;
                default:     ;
            endcase
        end
        cap_d = (cap_q & ~cap_clr) | edge_pulse;
    end

    // Control and capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q  <= RESET_OUT;
            dir_q  <= RESET_DIR;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // Combinational read mux; set/clear strobes and unused offsets read zero
    always_comb begin
        case (bus.address)
            PIO_DATA:    bus.readdata = in_sync;
            PIO_DIR:     bus.readdata = dir_q;
            PIO_IRQMASK: bus.readdata = mask_q;
            PIO_EDGECAP: bus.readdata = cap_q;
            default:     bus.readdata = '0;
        endcase
    end

    // Pin-side outputs and level interrupt straight from the registers
    always_comb begin
        out_port = out_q;
        oe_port  = dir_q;
        irq      = |(cap_q & mask_q);
    end

endmodule

// File: tb/tb_pio_ext.sv
// Directed bench: three ports (rise/fall/any capture) share pins and bus
// stimulus; expectations go through a scoreboard queue.
module tb_pio_ext;
    import pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_port = 8'h00;
    logic [7:0] out0, out1, out2, oe0, oe1, oe2;
    logic       irq0, irq1, irq2;
    logic [7:0] r0, r1, r2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    pio_ext_if #(.WIDTH(8)) b0 ();
    pio_ext_if #(.WIDTH(8)) b1 ();
    pio_ext_if #(.WIDTH(8)) b2 ();

    pio_ext #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F),
              .EDGE_MODE(PIO_EDGE_RISE), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0), .in_port(in_port),
        .out_port(out0), .oe_port(oe0), .irq(irq0));
    pio_ext #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F),
              .EDGE_MODE(PIO_EDGE_FALL), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1), .in_port(in_port),
        .out_port(out1), .oe_port(oe1), .irq(irq1));
    pio_ext #(.WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F),
              .EDGE_MODE(PIO_EDGE_ANY), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(b2), .in_port(in_port),
        .out_port(out2), .oe_port(oe2), .irq(irq2));

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive_bus(input logic cs, input logic wn, input logic [2:0] a,
                             input logic [7:0] d);
        b0.chipselect = cs; b1.chipselect = cs; b2.chipselect = cs;
        b0.write_n    = wn; b1.write_n    = wn; b2.write_n    = wn;
        b0.address    = a;  b1.address    = a;  b2.address    = a;
        b0.writedata  = d;  b1.writedata  = d;  b2.writedata  = d;
    endtask

    // One write cycle; returns at the negedge after the write edge
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        drive_bus(1'b1, 1'b0, a, d);
        @(negedge clk);
        drive_bus(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic bus_read(input logic [2:0] a);
        drive_bus(1'b0, 1'b1, a, 8'h00);
        #1;
        r0 = b0.readdata;
        r1 = b1.readdata;
        r2 = b2.readdata;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_bus(1'b0, 1'b1, 3'd0, 8'h00);
        #12;
        // Reset values while reset_n is low
        expect_val("rst_out", 8'hA5);  check(out0);
        expect_val("rst_oe", 8'h0F);   check(oe0);
        expect_val("rst_irq", 8'h00);  check({7'b0, irq0});
        bus_read(PIO_IRQMASK); expect_val("rst_mask", 8'h00); check(r0);
        bus_read(PIO_EDGECAP); expect_val("rst_cap", 8'h00);  check(r0);
        bus_read(PIO_DATA);    expect_val("rst_data", 8'h00); check(r0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Output data load, atomic set and clear
        bus_write(PIO_DATA, 8'h3C);   expect_val("out_load", 8'h3C); check(out0);
        bus_write(PIO_OUTSET, 8'h81); expect_val("out_set", 8'hBD);  check(out0);
        bus_write(PIO_OUTCLR, 8'h0C); expect_val("out_clr", 8'hB1);  check(out0);
        for (int a = 4; a < 8; a++) begin
            bus_read(3'(a));
            expect_val($sformatf("read_zero_%0d", a), 8'h00);
            check(r0);
        end
        cycles(1);
        bus_write(PIO_DIR, 8'hF0); expect_val("oe_load", 8'hF0); check(oe0);
        bus_read(PIO_DIR);  expect_val("dir_read", 8'hF0);  check(r0);
        bus_read(PIO_DATA); expect_val("data_idle", 8'h00); check(r0);

        // Rising edge on bit0 with irq masked in
        bus_write(PIO_IRQMASK, 8'h01);
        in_port = 8'h01;
        cycles(1);
        bus_read(PIO_DATA);    expect_val("sync_lat1", 8'h00); check(r0);
        cycles(1);
        bus_read(PIO_DATA);    expect_val("sync_lat2", 8'h01); check(r0);
        bus_read(PIO_EDGECAP); expect_val("cap_early", 8'h00); check(r0);
        expect_val("irq_early", 8'h00); check({7'b0, irq0});
        cycles(1);
        bus_read(PIO_EDGECAP);
        expect_val("cap_rise", 8'h01);      check(r0);
        expect_val("cap_fall_none", 8'h00); check(r1);
        expect_val("cap_any_rise", 8'h01);  check(r2);
        expect_val("irq_rise", 8'h01); check({7'b0, irq0});
        bus_write(PIO_EDGECAP, 8'h01);
        expect_val("irq_cleared", 8'h00); check({7'b0, irq0});
        bus_read(PIO_EDGECAP); expect_val("cap_cleared", 8'h00); check(r0);

        // Edge captured while masked; unmasking raises irq at once
        bus_write(PIO_IRQMASK, 8'h00);
        in_port = 8'h09;
        cycles(3);
        bus_read(PIO_EDGECAP);
        expect_val("cap_masked", 8'h08);     check(r0);
        expect_val("cap_fall_none2", 8'h00); check(r1);
        expect_val("cap_any_b3", 8'h08);     check(r2);
        expect_val("irq_masked", 8'h00); check({7'b0, irq0});
        bus_write(PIO_IRQMASK, 8'h08);
        expect_val("irq_unmask", 8'h01); check({7'b0, irq0});

        // Clear on bit2 lands on the same edge that detects a new bit2 edge
        in_port = 8'h0D;
        cycles(2);
        bus_write(PIO_EDGECAP, 8'h04);
        bus_read(PIO_EDGECAP); expect_val("cap_collide", 8'h0C); check(r0);
        expect_val("irq_collide", 8'h01); check({7'b0, irq0});
        bus_write(PIO_EDGECAP, 8'h04);
        bus_read(PIO_EDGECAP); expect_val("cap_clr_b2", 8'h08); check(r0);

        // Pulse bit5 0->1->0 across the three capture modes
        bus_write(PIO_EDGECAP, 8'hFF);
        bus_write(PIO_IRQMASK, 8'h20);
        in_port = 8'h2D;
        cycles(3);
        bus_read(PIO_EDGECAP);
        expect_val("p_rise_r", 8'h20); check(r0);
        expect_val("p_rise_f", 8'h00); check(r1);
        expect_val("p_rise_a", 8'h20); check(r2);
        in_port = 8'h0D;
        cycles(3);
        bus_read(PIO_EDGECAP);
        expect_val("p_fall_f", 8'h20); check(r1);
        expect_val("p_fall_a", 8'h20); check(r2);
        expect_val("irq_fall", 8'h01); check({7'b0, irq1});

        // Asynchronous reset mid-sequence with a capture in flight
        in_port = 8'h2D;
        cycles(1);
        #2;
        reset_n = 1'b0;
        #1;
        expect_val("arst_irq_r", 8'h00); check({7'b0, irq0});
        expect_val("arst_irq_f", 8'h00); check({7'b0, irq1});
        expect_val("arst_out", 8'hA5);   check(out0);
        expect_val("arst_oe", 8'h0F);    check(oe0);
        bus_read(PIO_EDGECAP);
        expect_val("arst_cap_r", 8'h00); check(r0);
        expect_val("arst_cap_f", 8'h00); check(r1);
        expect_val("arst_cap_a", 8'h00); check(r2);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(2);
        bus_read(PIO_DATA); expect_val("resync_data", 8'h2D); check(r0);

        if (sb.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
